alu_rsp_deserializer: RTL

- Receiver and decoder for the serial response stream that the ALU drives on `sout`.
- Sits in the testbench beside the stimulus side and feeds the scoreboard/monitor.
- Reassembles 11-bit frames into either a result response (4 data frames + 1 control frame) or an error response (1 control frame).
- Checks CRC3/parity and protocol framing, then presents one decoded response per `rsp_valid` pulse.

---
 rtl/alu_rsp_deserializer_if.sv | 31 +++
 rtl/alu_rsp_deserializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rsp_deserializer_if.sv
// Serial response bus between the ALU serial output and the response deserializer.
//   sout          : serial line driven by the ALU, idles high
//   rsp_valid     : one-cycle pulse, decoded response available
//   rsp_is_err    : 0 = result response, 1 = error response
//   rsp_data      : result C, first data frame is the MSB byte
//   rsp_flags     : Carry, Overflow, Zero, Negative from the result control frame
//   rsp_err_flags : error flags from the error control frame
//   rsp_chk_ok    : CRC3 (result) or parity (error) matched
//   proto_err     : one-cycle pulse, framing/sequence violation
interface alu_rsp_deserializer_if;
  logic        sout;
  logic        rsp_valid;
  logic        rsp_is_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [5:0]  rsp_err_flags;
  logic        rsp_chk_ok;
  logic        proto_err;

  // ALU / stimulus side
  modport master (
    output sout,
    input  rsp_valid, rsp_is_err, rsp_data, rsp_flags, rsp_err_flags, rsp_chk_ok, proto_err
  );

  // Deserializer side
  modport slave (
    input  sout,
    output rsp_valid, rsp_is_err, rsp_data, rsp_flags, rsp_err_flags, rsp_chk_ok, proto_err
  );
endinterface

// File: rtl/alu_rsp_deserializer.sv
// Receives 11-bit frames (start, type, d[7:0], stop) from the ALU serial line and
// decodes them into result responses (4 data + 1 control frame) or error responses
// (1 control frame), checking CRC3/parity and framing.
//   clk   : system clock, one serial bit per rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of alu_rsp_deserializer_if (sout in, decoded response out)
module alu_rsp_deserializer #(
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_rsp_deserializer_if.slave bus
);

  localparam int unsigned GAP_W  = $clog2(GAP_TIMEOUT + 1);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned NFRM_W = 3;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(8);
  localparam logic [NFRM_W-1:0] NUM_DATA  = NFRM_W'(4);
  localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(GAP_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BITS = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // CRC3, polynomial x^3+x+1, init 000, MSB first
  function automatic logic [2:0] crc3(input logic [36:0] word);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ word[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  logic [1:0]        r_state,       w_state;
  logic [BIT_W-1:0]  r_bit_cnt,     w_bit_cnt;
  logic [8:0]        r_shift,       w_shift;
  logic [NFRM_W-1:0] r_nfrm,        w_nfrm;
  logic [31:0]       r_data,        w_data;
  logic [GAP_W-1:0]  r_gap_cnt,     w_gap_cnt;
  logic              r_rsp_valid,   w_rsp_valid;
  logic              r_rsp_is_err,  w_rsp_is_err;
  logic [31:0]       r_rsp_data,    w_rsp_data;
  logic [3:0]        r_rsp_flags,   w_rsp_flags;
  logic [5:0]        r_rsp_eflags,  w_rsp_eflags;
  logic              r_rsp_chk_ok,  w_rsp_chk_ok;
  logic              r_proto_err,   w_proto_err;

  // Completed frame fields while in STOP
  logic       w_type;
  logic [7:0] w_byte;
  logic [2:0] w_crc;
  assign w_type = r_shift[8];
  assign w_byte = r_shift[7:0];
  assign w_crc  = crc3({r_data, 1'b0, w_byte[6:3]});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_nfrm       <= '0;
      r_data       <= '0;
      r_gap_cnt    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_is_err <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_flags  <= '0;
      r_rsp_eflags <= '0;
      r_rsp_chk_ok <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bit_cnt    <= w_bit_cnt;
      r_shift      <= w_shift;
      r_nfrm       <= w_nfrm;
      r_data       <= w_data;
      r_gap_cnt    <= w_gap_cnt;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_is_err <= w_rsp_is_err;
      r_rsp_data   <= w_rsp_data;
      r_rsp_flags  <= w_rsp_flags;
      r_rsp_eflags <= w_rsp_eflags;
      r_rsp_chk_ok <= w_rsp_chk_ok;
      r_proto_err  <= w_proto_err;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state      = r_state;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_nfrm       = r_nfrm;
    w_data       = r_data;
    w_gap_cnt    = r_gap_cnt;
    w_rsp_valid  = 1'b0;
    w_proto_err  = 1'b0;
    w_rsp_is_err = r_rsp_is_err;
    w_rsp_data   = r_rsp_data;
    w_rsp_flags  = r_rsp_flags;
    w_rsp_eflags = r_rsp_eflags;
    w_rsp_chk_ok = r_rsp_chk_ok;

    case (r_state)
      S_IDLE: begin
        w_nfrm    = '0;
        w_gap_cnt = '0;
        if (!bus.sout) begin
          w_state   = S_BITS;
          w_bit_cnt = '0;
        end
      end

      S_BITS: begin
        w_shift = {r_shift[7:0], bus.sout};
        if (r_bit_cnt == LAST_BIT) w_state = S_STOP;
        else                       w_bit_cnt = r_bit_cnt + BIT_W'(1);
      end

      S_STOP: begin
        w_state = S_IDLE;
        if (!bus.sout) begin
          w_proto_err = 1'b1;
        end else if (!w_type) begin
          if (r_nfrm < NUM_DATA) begin
            w_data    = {r_data[23:0], w_byte};
            w_nfrm    = r_nfrm + NFRM_W'(1);
            w_gap_cnt = '0;
            w_state   = S_GAP;
          end else begin
            w_proto_err = 1'b1;
          end
        end else if (r_nfrm == '0 && w_byte[7]) begin
          w_rsp_valid  = 1'b1;
          w_rsp_is_err = 1'b1;
          w_rsp_eflags = w_byte[6:1];
          w_rsp_chk_ok = ~^w_byte;
        end else if (r_nfrm == NUM_DATA && !w_byte[7]) begin
          w_rsp_valid  = 1'b1;
          w_rsp_is_err = 1'b0;
          w_rsp_data   = r_data;
          w_rsp_flags  = w_byte[6:3];
          w_rsp_chk_ok = (w_byte[2:0] == w_crc);
        end else begin
          w_proto_err = 1'b1;
        end
      end

      S_GAP: begin
        if (!bus.sout) begin
          w_state   = S_BITS;
          w_bit_cnt = '0;
          w_gap_cnt = '0;
        end else if (r_gap_cnt >= GAP_LIMIT) begin
          w_proto_err = 1'b1;
          w_state     = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_is_err    = r_rsp_is_err;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_flags     = r_rsp_flags;
  assign bus.rsp_err_flags = r_rsp_eflags;
  assign bus.rsp_chk_ok    = r_rsp_chk_ok;
  assign bus.proto_err     = r_proto_err;

endmodule
